// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths and owner encoding.
package ram_port_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  owner_e r_ptr;
  logic   w_pick_a;

  always_comb begin
    w_pick_a  = i_valid_a && (!i_valid_b || r_ptr == OWNER_A);
    o_grant_a = !rst && w_pick_a;
    o_grant_b = !rst && i_valid_b && !w_pick_a;
  end

  // Priority always moves to whichever side lost (or was idle) this grant.
  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= OWNER_A;
    else if (o_grant_a) r_ptr <= OWNER_B;
    else if (o_grant_b) r_ptr <= OWNER_A;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one single-port RAM; 3-stage in-order pipeline
// returns the pre-access word to the owning requester.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_address,
  input  logic [DATA_WIDTH-1:0] a_req_d,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_q,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_address,
  input  logic [DATA_WIDTH-1:0] b_req_d,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_q,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  w_grant_a, w_grant_b, w_accept, w_we;
  owner_e                w_owner;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_d;

  logic                  r_s1_valid, r_s2_valid;
  owner_e                r_s1_owner, r_s2_owner;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_d;
  logic                  r_a_rsp_valid, r_b_rsp_valid;
  logic [DATA_WIDTH-1:0] r_a_rsp_q, r_b_rsp_q;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid_a (a_req_valid),
    .i_valid_b (b_req_valid),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  always_comb begin
    w_accept = w_grant_a || w_grant_b;
    w_owner  = w_grant_b ? OWNER_B : OWNER_A;
    w_we     = w_grant_b ? b_req_we      : a_req_we;
    w_addr   = w_grant_b ? b_req_address : a_req_address;
    w_d      = w_grant_b ? b_req_d       : a_req_d;
  end

  // S1: issue to RAM; address/data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_owner    <= OWNER_A;
      r_ram_we      <= 1'b0;
      r_ram_address <= '0;
      r_ram_d       <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_ram_we   <= w_accept && w_we;
      if (w_accept) begin
        r_s1_owner    <= w_owner;
        r_ram_address <= w_addr;
        r_ram_d       <= w_d;
      end
    end
  end

  // S2 tracks the RAM read latency; S3 captures ram_q for the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_owner    <= OWNER_A;
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
      r_a_rsp_q     <= '0;
      r_b_rsp_q     <= '0;
    end else begin
      r_s2_valid    <= r_s1_valid;
      r_s2_owner    <= r_s1_owner;
      r_a_rsp_valid <= r_s2_valid && r_s2_owner == OWNER_A;
      r_b_rsp_valid <= r_s2_valid && r_s2_owner == OWNER_B;
      if (r_s2_valid && r_s2_owner == OWNER_A) r_a_rsp_q <= ram_q;
      if (r_s2_valid && r_s2_owner == OWNER_B) r_b_rsp_q <= ram_q;
    end
  end

  assign a_req_ready = w_grant_a;
  assign b_req_ready = w_grant_b;
  assign ram_we      = r_ram_we;
  assign ram_address = r_ram_address;
  assign ram_d       = r_ram_d;
  assign a_rsp_valid = r_a_rsp_valid;
  assign a_rsp_q     = r_a_rsp_q;
  assign b_rsp_valid = r_b_rsp_valid;
  assign b_rsp_q     = r_b_rsp_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: behavioural RAM, arbitration/memory
// reference model, and an independent response monitor.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;

  typedef struct { bit we; bit [AW-1:0] addr; bit [DW-1:0] d; } req_t;
  typedef struct { bit owner; bit [DW-1:0] q; int due; } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_address;
  logic [DW-1:0] a_req_d, a_rsp_q;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_address;
  logic [DW-1:0] b_req_d, b_rsp_q;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_d, ram_q;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_address(a_req_address), .a_req_d(a_req_d),
    .a_rsp_valid(a_rsp_valid), .a_rsp_q(a_rsp_q),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_address(b_req_address), .b_req_d(b_req_d),
    .b_rsp_valid(b_rsp_valid), .b_rsp_q(b_rsp_q),
    .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM sitting outside the DUT: registered read, read-before-write, no reset.
  logic [DW-1:0] ram_mem [2**AW];
  bit [DW-1:0]   ref_mem [2**AW];
  bit            ram_live = 1'b0;
  always @(posedge clk) begin
    if (ram_live) begin
      ram_q <= ram_mem[ram_address];
      if (ram_we) ram_mem[ram_address] <= ram_d;
    end
  end

  req_t qa[$], qb[$];
  exp_t sb[$];
  bit   acc_a = 0, acc_b = 0, gaps = 0;
  int   grants_a = 0, grants_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester drivers: hold a request until the model reports it accepted.
  initial begin
    req_t r;
    a_req_valid = 0; a_req_we = 0; a_req_address = '0; a_req_d = '0;
    b_req_valid = 0; b_req_we = 0; b_req_address = '0; b_req_d = '0;
    forever begin
      @(posedge clk); #1;
      if (acc_a || !a_req_valid) begin
        acc_a = 0; a_req_valid = 0;
        if (qa.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          r = qa.pop_front();
          a_req_valid = 1; a_req_we = r.we; a_req_address = r.addr; a_req_d = r.d;
        end
      end
      if (acc_b || !b_req_valid) begin
        acc_b = 0; b_req_valid = 0;
        if (qb.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          r = qb.pop_front();
          b_req_valid = 1; b_req_we = r.we; b_req_address = r.addr; b_req_d = r.d;
        end
      end
    end
  end

  // Reference model: round-robin rule plus a word array updated in grant order.
  bit          m_ptr_b = 0;
  bit          prev_acc = 0, prev_we = 0;
  bit [AW-1:0] last_addr = '0;
  bit [DW-1:0] prev_d = '0;
  always @(negedge clk) begin
    bit ga, gb, we;
    bit [AW-1:0] ad;
    bit [DW-1:0] dd;
    chk("ready_a", a_req_ready, rst ? 1'b0 : 1'b0 | (a_req_valid && (!b_req_valid || !m_ptr_b)));
    chk("ready_b", b_req_ready, rst ? 1'b0 : 1'b0 | (b_req_valid && (!a_req_valid || m_ptr_b)));
    if (rst) begin
      m_ptr_b = 0; prev_acc = 0; last_addr = '0;
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.pop_back();
    end else begin
      chk("ram_we", ram_we, prev_acc && prev_we);
      chk("ram_address", ram_address, last_addr);
      if (prev_acc && prev_we) chk("ram_d", ram_d, prev_d);
      ga = a_req_valid && (!b_req_valid || !m_ptr_b);
      gb = b_req_valid && !ga;
      prev_acc = ga || gb;
      if (prev_acc) begin
        we = ga ? a_req_we : b_req_we;
        ad = ga ? a_req_address : b_req_address;
        dd = ga ? a_req_d : b_req_d;
        sb.push_back('{owner: gb, q: ref_mem[ad], due: cyc + 3});
        if (we) ref_mem[ad] = dd;
        prev_we = we; prev_d = dd; last_addr = ad;
        m_ptr_b = ga;
        if (ga) begin acc_a = 1; grants_a++; end
        else    begin acc_b = 1; grants_b++; end
      end
    end
  end

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 2) begin
      if (a_rsp_valid && b_rsp_valid) chk("rsp_exclusive", 2'b11, 2'b01);
      if (a_rsp_valid || b_rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", {a_rsp_valid, b_rsp_valid}, 2'b00);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", b_rsp_valid, e.owner);
          chk("rsp_q", e.owner ? b_rsp_q : a_rsp_q, e.q);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 1'b0, 1'b1);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((qa.size() || qb.size() || a_req_valid || b_req_valid || sb.size()) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) chk("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input bit port);
    int g0 = port ? grants_b : grants_a;
    int n = 0;
    while ((port ? grants_b : grants_a) == g0 && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("grant_timeout", n, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    // Contention straight out of reset: 3 requests each side.
    for (int i = 0; i < 3; i++) begin
      qa.push_back('{we: 0, addr: 7'(10 + i), d: '0});
      qb.push_back('{we: 0, addr: 7'(20 + i), d: '0});
    end
    @(posedge clk); ram_live = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_rsp_q", {a_rsp_q, b_rsp_q}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_a_ready", a_req_ready, 1);
    wait_idle(200);
    chk("contention_grants", {grants_a[7:0], grants_b[7:0]}, 16'h0303);

    // Write then read the same address back-to-back on A.
    qa.push_back('{we: 1, addr: 7'd5, d: 32'hDEADBEEF});
    qa.push_back('{we: 0, addr: 7'd5, d: '0});
    wait_idle(200);

    // Cross-port RAW at the top address; address 0 untouched.
    qb.push_back('{we: 1, addr: 7'd127, d: 32'h1});
    wait_grant(1);
    qa.push_back('{we: 0, addr: 7'd127, d: '0});
    qa.push_back('{we: 0, addr: 7'd0, d: '0});
    wait_idle(200);

    // Reset one cycle after a read is accepted: its response is dropped.
    qa.push_back('{we: 0, addr: 7'd33, d: '0});
    wait_grant(0);
    pulse_reset();
    wait_idle(200);

    // Reset one cycle after a write is accepted: the write still lands.
    qa.push_back('{we: 1, addr: 7'd9, d: 32'h55});
    wait_grant(0);
    pulse_reset();
    wait_idle(200);
    qa.push_back('{we: 0, addr: 7'd9, d: '0});
    wait_idle(200);

    // Ten back-to-back reads on B alone.
    for (int i = 0; i < 10; i++) qb.push_back('{we: 0, addr: 7'(40 + i), d: '0});
    wait_idle(200);

    // Random mixed traffic on a small address pool plus the top address.
    gaps = 1;
    for (int i = 0; i < 150; i++) begin
      qa.push_back('{we: 1'($urandom_range(0, 1)),
                     addr: ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(0, 7)),
                     d: $urandom});
      qb.push_back('{we: 1'($urandom_range(0, 1)),
                     addr: ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(0, 7)),
                     d: $urandom});
    end
    wait_idle(3000);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the team's single-port 128x32 synchronous RAM. Requester A and requester B each issue word read/write requests through a valid/ready handshake. The block grants at most one request per cycle with round-robin fairness and drives the RAM's we/address/d inputs from registers. It returns one in-order response per accepted request, carrying the pre-access word value, to the owning requester. It sits between two bus masters (e.g. a DMA engine and a CPU-side port) and the RAM, which stays instantiated outside this block.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per RAM word
- ADDR_WIDTH, 7, RAM address bits (depth 2**ADDR_WIDTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- a_req_valid  in  1  requester A has a request
- a_req_ready  out  1  A's request accepted this cycle
- a_req_we  in  1  1 = write, 0 = read
- a_req_address  in  ADDR_WIDTH  word address
- a_req_d  in  DATA_WIDTH  write data
- a_rsp_valid  out  1  one-cycle response pulse for A
- a_rsp_q  out  DATA_WIDTH  word value before the access
- b_req_valid, b_req_ready, b_req_we, b_req_address, b_req_d, b_rsp_valid, b_rsp_q: same as A, for requester B
- ram_we  out  1  RAM write enable (registered)
- ram_address  out  ADDR_WIDTH  RAM address (registered)
- ram_d  out  DATA_WIDTH  RAM write data (registered)
- ram_q  in  DATA_WIDTH  RAM registered read data; valid the cycle after the address is presented; read-before-write

## Operation
- Handshake: a request transfers in a cycle where req_valid && req_ready.
  - req_ready depends combinationally on both valids and the priority pointer.
  - req_ready is 0 while rst = 1 and whenever the requester's valid is 0.
  - A requester holds valid, we, address and d stable until accepted.
- Grant:
  - If only A is valid, grant A. If only B is valid, grant B.
  - If both are valid, grant the requester named by the priority pointer.
  - After any grant, the pointer moves to the non-granted requester.
  - Under continuous contention, grants strictly alternate.
  - No response backpressure: rsp has no ready, so acceptance never stalls.
- Pipeline (S1 issue, S2 RAM read, S3 response):
  - S1 registers: s1_valid, s1_owner, ram_we (= we && accepted), ram_address, ram_d.
  - S2 registers: s2_valid, s2_owner.
  - S3 registers: x_rsp_valid and x_rsp_q, captured from ram_q for owner x.
- Every accepted request produces exactly one response on its owner's port.
  - Responses arrive in acceptance order.
  - Writes are acknowledged too; their rsp_q is the old word.
- Idle cycles: ram_we = 0. ram_address and ram_d hold their last values.
- Reset values: a_req_ready, b_req_ready = 0; ram_we = 0; ram_address = 0; ram_d = 0; a/b_rsp_valid = 0; a/b_rsp_q = 0; s1/s2 valids = 0; priority pointer = A.
- Reset mid-operation:
  - All in-flight responses are dropped.
  - A write already on ram_we at the reset edge is committed by the RAM, because the RAM has no reset. Its response is suppressed.
- Addresses are not range-checked. The full 0..2**ADDR_WIDTH-1 range is legal, with no wrap logic.

## Timing
- Request accepted in cycle t:
  - ram_* driven in t+1; the RAM samples at the end of t+1.
  - ram_q is valid in t+2.
  - x_rsp_valid = 1 and x_rsp_q are valid in cycle t+3 only.
- Fixed latency is 3 cycles. Throughput is 1 request per cycle summed over both ports.
- Read-after-write to the same address is hazard-free with no forwarding logic.
  - A write accepted at t commits at the end of t+1.
  - A read accepted at t+1 or later returns the new data.
- Both ports can never receive a response in the same cycle.

## Structure
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, owner encoding (OWNER_A = 0, OWNER_B = 1).
- Sub-module: rr_arbiter2. It is combinational grant from (valid_a, valid_b, pointer) plus the registered pointer update.
- The top level holds the S1–S3 pipeline registers and response demux.

## Test plan
- Reset: rst = 1 for 2 cycles with a_req_valid = 1 → all outputs 0, ready 0. First cycle after release → a_req_ready = 1.
- Write then read:
  - A writes addr 5 = 0xDEADBEEF at t → ram_we = 1, ram_address = 5 in t+1; a_rsp_valid in t+3 with a_rsp_q = old value.
  - A reads addr 5 at t+1 → a_rsp_q = 0xDEADBEEF in t+4.
- Contention: both valid for 6 cycles from reset → grants A,B,A,B,A,B; a_rsp_valid and b_rsp_valid alternate from cycle 3, never together.
- Cross-port RAW: B writes addr 127 = 0x00000001 at t, A reads 127 at t+1 → a_rsp_q = 0x00000001 in t+4. Addr 0 is unaffected.
- Reset mid-flight:
  - A read accepted at t and rst = 1 in t+1 → no a_rsp_valid at t+3.
  - A write of 0x55 to addr 9 accepted at t with rst in t+1 → a later read of 9 returns 0x55.
- Single-port stream: B issues 10 back-to-back reads while A idles → 10 b_rsp_valid pulses in consecutive cycles starting at t+3, with data in order.
